// File: rtl/alu_pkg.sv
// Shared ALU definitions used by the dispatch controller and the result-select mux.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_DIV = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_OR  = 4'd5;
    localparam logic [3:0] OP_XOR = 4'd6;
    localparam logic [3:0] OP_LI  = 4'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WAIT = 2'd2,
        S_WB   = 2'd3
    } state_t;

    function automatic logic is_multicycle(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/dispatch_timeout_cnt.sv
// Wait timer for multi-cycle units: down-counter loaded on clear, terminal flag at zero.
module dispatch_timeout_cnt #(
    parameter int TIMEOUT = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] cnt;

    // Loading TIMEOUT-1 gives exactly TIMEOUT enabled cycles before tc.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= CNT_W'(TIMEOUT - 1);
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign tc = (cnt == '0);

endmodule

// File: rtl/op_dispatch_ctrl.sv
// Issue-side ALU controller: latches one instruction, enables one unit, waits, writes back.
// state  | meaning
// S_IDLE | ready for an instruction; rejects illegal opcodes and divide by zero
// S_EXEC | unit enabled for the first cycle; single-cycle ops go straight to write-back
// S_WAIT | waiting on mul_done/div_done, bounded by the timeout counter
// S_WB   | one-cycle write strobe with unit_en and sel_opcode held
module op_dispatch_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 3,
    parameter int TIMEOUT = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [3:0]        op_opcode,
    input  logic [DATA_W-1:0] rs1_val,
    input  logic [DATA_W-1:0] rs2_val,
    input  logic [DATA_W-1:0] imm,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        unit_en,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    input  logic              mul_done,
    input  logic              div_done,
    output logic [3:0]        sel_opcode,
    output logic              wb_en,
    output logic [ADDR_W-1:0] wb_addr,
    output logic              illegal_op,
    output logic              div_zero,
    output logic              timeout_err
);
    state_t            state;
    logic [3:0]        opcode_q;
    logic [ADDR_W-1:0] rd_q;
    logic              cnt_clr;
    logic              cnt_en;
    logic              cnt_tc;
    logic              done_match;

    assign cnt_clr    = (state == S_EXEC);
    assign cnt_en     = (state == S_WAIT);
    assign done_match = (opcode_q == OP_MUL) ? mul_done : div_done;

    dispatch_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .en  (cnt_en),
        .tc  (cnt_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            instr_ready <= 1'b1;
            opcode_q    <= '0;
            rd_q        <= '0;
            op_a        <= '0;
            op_b        <= '0;
            unit_en     <= '0;
            sel_opcode  <= '0;
            wb_en       <= 1'b0;
            wb_addr     <= '0;
            illegal_op  <= 1'b0;
            div_zero    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            illegal_op  <= 1'b0;
            div_zero    <= 1'b0;
            timeout_err <= 1'b0;
            wb_en       <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (instr_valid) begin
                        opcode_q <= op_opcode;
                        rd_q     <= rd_addr;
                        op_a     <= rs1_val;
                        op_b     <= (op_opcode == OP_LI) ? imm : rs2_val;
                        if (op_opcode > OP_LI) begin
                            illegal_op <= 1'b1;
                        end else if ((op_opcode == OP_DIV) && (rs2_val == '0)) begin
                            div_zero <= 1'b1;
                        end else begin
                            state       <= S_EXEC;
                            instr_ready <= 1'b0;
                            unit_en     <= 8'(1) << op_opcode[2:0];
                            sel_opcode  <= op_opcode;
                        end
                    end
                end
                S_EXEC: begin
                    if (!is_multicycle(opcode_q) || done_match) begin
                        state   <= S_WB;
                        wb_en   <= 1'b1;
                        wb_addr <= rd_q;
                    end else begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (done_match) begin
                        state   <= S_WB;
                        wb_en   <= 1'b1;
                        wb_addr <= rd_q;
                    end else if (cnt_tc) begin
                        state       <= S_IDLE;
                        timeout_err <= 1'b1;
                        instr_ready <= 1'b1;
                        unit_en     <= '0;
                        sel_opcode  <= '0;
                    end
                end
                S_WB: begin
                    state       <= S_IDLE;
                    instr_ready <= 1'b1;
                    unit_en     <= '0;
                    sel_opcode  <= '0;
                    wb_addr     <= '0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
